// File: rtl/bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_2m
// Brief    : Two-master round-robin arbiter/mux for the 8-bit data-memory bus,
//            with a per-grant hold watchdog.
// Revision : 1.0
// ============================================================================
module bus_arbiter_2m #(
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_bus_req,
    output logic             m0_bus_grant,
    input  logic [7:0]       m0_addr,
    input  logic             m0_wr,
    input  logic             m0_rd,
    input  logic [7:0]       m0_wdata,
    input  logic             m1_bus_req,
    output logic             m1_bus_grant,
    input  logic [7:0]       m1_addr,
    input  logic             m1_wr,
    input  logic             m1_rd,
    input  logic [7:0]       m1_wdata,
    output logic [7:0]       s_addr,
    output logic             s_wr,
    output logic             s_rd,
    output logic [7:0]       s_wdata,
    input  logic [7:0]       s_rdata,
    output logic [7:0]       m_rdata,
    output logic             hold_viol,
    output logic             hold_viol_id,
    input  logic             hold_viol_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_cnt_sat  = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_owner;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_hold_viol;
    logic             r_hold_viol_id;
    logic             w_other_req;
    logic             w_fire;

    always_comb begin
        w_next_state = r_state;
        w_other_req  = 1'b0;
        s_addr       = 8'h00;
        s_wr         = 1'b0;
        s_rd         = 1'b0;
        s_wdata      = 8'h00;
        case (r_state)
            IDLE: begin
                if (m0_bus_req && m1_bus_req)
                    w_next_state = r_last_owner ? OWN0 : OWN1;
                else if (m0_bus_req)
                    w_next_state = OWN0;
                else if (m1_bus_req)
                    w_next_state = OWN1;
            end
            OWN0: begin
                w_other_req = m1_bus_req;
                s_addr      = m0_addr;
                s_wr        = m0_wr;
                s_rd        = m0_rd;
                s_wdata     = m0_wdata;
                if (!m0_bus_req)
                    w_next_state = m1_bus_req ? OWN1 : IDLE;
            end
            OWN1: begin
                w_other_req = m0_bus_req;
                s_addr      = m1_addr;
                s_wr        = m1_wr;
                s_rd        = m1_rd;
                s_wdata     = m1_wdata;
                if (!m1_bus_req)
                    w_next_state = m0_bus_req ? OWN0 : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Watchdog only counts contention: the other master must be waiting.
    assign w_fire = w_other_req && (r_hold_cnt == c_max_hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_last_owner   <= 1'b1;
            r_hold_cnt     <= '0;
            r_hold_viol    <= 1'b0;
            r_hold_viol_id <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (r_state == OWN0 && w_next_state != OWN0)
                r_last_owner <= 1'b0;
            else if (r_state == OWN1 && w_next_state != OWN1)
                r_last_owner <= 1'b1;

            if (w_next_state == IDLE || w_next_state != r_state)
                r_hold_cnt <= '0;
            else if (w_other_req && r_hold_cnt != c_cnt_sat)
                r_hold_cnt <= r_hold_cnt + 1'b1;

            // A new violation takes priority over a simultaneous clear.
            if (w_fire) begin
                r_hold_viol <= 1'b1;
                if (!r_hold_viol)
                    r_hold_viol_id <= (r_state == OWN1);
            end else if (hold_viol_clr) begin
                r_hold_viol    <= 1'b0;
                r_hold_viol_id <= 1'b0;
            end
        end
    end

    assign m0_bus_grant = (r_state == OWN0);
    assign m1_bus_grant = (r_state == OWN1);
    assign m_rdata      = s_rdata;
    assign hold_viol    = r_hold_viol;
    assign hold_viol_id = r_hold_viol_id;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_2m
// Brief    : Directed scoreboard bench for bus_arbiter_2m (MAX_HOLD = 4).
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter_2m;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_bus_req, m0_bus_grant, m0_wr, m0_rd;
    logic [7:0] m0_addr, m0_wdata;
    logic       m1_bus_req, m1_bus_grant, m1_wr, m1_rd;
    logic [7:0] m1_addr, m1_wdata;
    logic [7:0] s_addr, s_wdata, s_rdata, m_rdata;
    logic       s_wr, s_rd;
    logic       hold_viol, hold_viol_id, hold_viol_clr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic [7:0] addr;
        logic       wr;
        logic       rd;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       viol;
        logic       vid;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    bus_arbiter_2m #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_bus_req    (m0_bus_req),
        .m0_bus_grant  (m0_bus_grant),
        .m0_addr       (m0_addr),
        .m0_wr         (m0_wr),
        .m0_rd         (m0_rd),
        .m0_wdata      (m0_wdata),
        .m1_bus_req    (m1_bus_req),
        .m1_bus_grant  (m1_bus_grant),
        .m1_addr       (m1_addr),
        .m1_wr         (m1_wr),
        .m1_rd         (m1_rd),
        .m1_wdata      (m1_wdata),
        .s_addr        (s_addr),
        .s_wr          (s_wr),
        .s_rd          (s_rd),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .m_rdata       (m_rdata),
        .hold_viol     (hold_viol),
        .hold_viol_id  (hold_viol_id),
        .hold_viol_clr (hold_viol_clr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Push the expected post-edge outputs, clock once, then pop and compare.
    task automatic step(input string tag, input logic g0, input logic g1,
                        input logic v, input logic vid);
        exp_t  e;
        string t;
        e.g0    = g0;
        e.g1    = g1;
        e.addr  = g0 ? m0_addr  : (g1 ? m1_addr  : 8'h00);
        e.wr    = g0 ? m0_wr    : (g1 ? m1_wr    : 1'b0);
        e.rd    = g0 ? m0_rd    : (g1 ? m1_rd    : 1'b0);
        e.wdata = g0 ? m0_wdata : (g1 ? m1_wdata : 8'h00);
        e.rdata = s_rdata;
        e.viol  = v;
        e.vid   = vid;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".g0"},    {7'b0, m0_bus_grant}, {7'b0, e.g0});
        chk({t, ".g1"},    {7'b0, m1_bus_grant}, {7'b0, e.g1});
        chk({t, ".addr"},  s_addr,               e.addr);
        chk({t, ".wr"},    {7'b0, s_wr},         {7'b0, e.wr});
        chk({t, ".rd"},    {7'b0, s_rd},         {7'b0, e.rd});
        chk({t, ".wdata"}, s_wdata,              e.wdata);
        chk({t, ".rdata"}, m_rdata,              e.rdata);
        chk({t, ".viol"},  {7'b0, hold_viol},    {7'b0, e.viol});
        chk({t, ".vid"},   {7'b0, hold_viol_id}, {7'b0, e.vid});
    endtask

    initial begin
        rst = 1'b1;
        m0_bus_req = 1'b0; m0_addr = 8'h00; m0_wr = 1'b0; m0_rd = 1'b0; m0_wdata = 8'h00;
        m1_bus_req = 1'b0; m1_addr = 8'h00; m1_wr = 1'b0; m1_rd = 1'b0; m1_wdata = 8'h00;
        s_rdata = 8'h00;
        hold_viol_clr = 1'b0;

        step("rst_a", 0, 0, 0, 0);
        step("rst_b", 0, 0, 0, 0);
        rst = 1'b0;

        // Idle bus with a non-requesting master driving strobes
        m1_addr = 8'hFF; m1_wr = 1'b1; m1_rd = 1'b1; m1_wdata = 8'h11;
        step("idle_m1_strobes", 0, 0, 0, 0);

        // Single M0 request, write transfer
        m0_bus_req = 1'b1; m0_addr = 8'h3C; m0_wr = 1'b1; m0_wdata = 8'hA5;
        step("m0_grant", 1, 0, 0, 0);
        step("m0_hold", 1, 0, 0, 0);
        m0_bus_req = 1'b0; m0_wr = 1'b0;
        step("m0_release", 0, 0, 0, 0);

        // Tie after reset goes to M0, then a gapless handoff
        rst = 1'b1;
        step("rst2", 0, 0, 0, 0);
        rst = 1'b0;
        m0_bus_req = 1'b1; m1_bus_req = 1'b1;
        m1_wr = 1'b0; m1_rd = 1'b1; m1_addr = 8'h42;
        step("tie_m0", 1, 0, 0, 0);
        m0_bus_req = 1'b0;
        step("handoff_m1", 0, 1, 0, 0);
        m1_bus_req = 1'b0;
        step("m1_release", 0, 0, 0, 0);
        m0_bus_req = 1'b1; m1_bus_req = 1'b1;
        step("tie2_m0", 1, 0, 0, 0);
        m0_bus_req = 1'b0; m1_bus_req = 1'b0;
        step("idle2", 0, 0, 0, 0);

        // M0 watchdog: fires after the 5th contention cycle
        m0_bus_req = 1'b1; m0_addr = 8'h10; m0_rd = 1'b1;
        step("wd_grant0", 1, 0, 0, 0);
        m1_bus_req = 1'b1;
        for (int i = 0; i < 4; i++) step("wd_count", 1, 0, 0, 0);
        step("wd_fire0", 1, 0, 1, 0);
        step("wd_sticky", 1, 0, 1, 0);
        m0_bus_req = 1'b0;
        step("wd_handoff", 0, 1, 1, 0);

        // M1 holds 10 cycles with M0 waiting; its violation keeps id 0
        m0_bus_req = 1'b1; s_rdata = 8'h5A; m1_addr = 8'h77; m1_wr = 1'b1; m1_wdata = 8'hC3;
        for (int i = 0; i < 10; i++) step("m1_no_preempt", 0, 1, 1, 0);
        m1_bus_req = 1'b0;
        step("m0_after_m1", 1, 0, 1, 0);

        hold_viol_clr = 1'b1;
        step("viol_clear", 1, 0, 0, 0);
        hold_viol_clr = 1'b0;

        // Reset while M1 owns, then a tie goes to M0
        m0_bus_req = 1'b0; m1_bus_req = 1'b1;
        step("own1_again", 0, 1, 0, 0);
        rst = 1'b1; m0_bus_req = 1'b1;
        step("rst_mid", 0, 0, 0, 0);
        rst = 1'b0;
        step("post_rst_tie", 1, 0, 0, 0);

        m0_bus_req = 1'b0; m1_bus_req = 1'b0;
        step("final_idle", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Two-master arbiter and multiplexer for the 8-bit data-memory bus.
- Master 0 is the CPU master bus interface (req/grant, addr, wr, rd, data). Master 1 is a second bus master such as a DMA or the debug engine.
- Grants the shared slave bus to one master at a time using round-robin priority, and drives the selected master's address, strobes and write data onto the slave side.
- Runs a per-grant watchdog that flags masters holding the bus too long.

Parameters:
- MAX_HOLD, 64, grant-hold limit in clock cycles; the watchdog fires when it is exceeded while the other master is waiting.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- m0_bus_req  input  1  master 0 bus request
- m0_bus_grant  output  1  master 0 bus grant
- m0_addr  input  8  master 0 address
- m0_wr  input  1  master 0 write strobe
- m0_rd  input  1  master 0 read strobe
- m0_wdata  input  8  master 0 write data
- m1_bus_req  input  1  master 1 bus request
- m1_bus_grant  output  1  master 1 bus grant
- m1_addr  input  8  master 1 address
- m1_wr  input  1  master 1 write strobe
- m1_rd  input  1  master 1 read strobe
- m1_wdata  input  8  master 1 write data
- s_addr  output  8  slave-side address
- s_wr  output  1  slave-side write strobe
- s_rd  output  1  slave-side read strobe
- s_wdata  output  8  slave-side write data
- s_rdata  input  8  slave read data (OR of all slaves)
- m_rdata  output  8  read data broadcast to both masters; equals s_rdata combinationally
- hold_viol  output  1  sticky watchdog flag
- hold_viol_id  output  1  master that caused the first violation
- hold_viol_clr  input  1  clears hold_viol and hold_viol_id

Behaviour:
- Clock and reset: clk only; rst is synchronous and active-high.
- Reset values: state=IDLE, both grants 0, s_* = 0, last_owner=1 (so M0 wins the first tie), hold counter 0, hold_viol=0, hold_viol_id=0.
- FSM has three states: IDLE, OWN0, OWN1. Grants are registered: m0_bus_grant=(state==OWN0) and m1_bus_grant=(state==OWN1).
- IDLE transitions:
  - only m0_bus_req -> OWN0
  - only m1_bus_req -> OWN1
  - both -> the master that is not last_owner
  - neither -> stay in IDLE
- Request-to-grant latency from IDLE is 1 cycle: req sampled high at edge n gives grant high after edge n.
- OWNx transitions:
  - While mx_bus_req=1, stay in OWNx. There is no preemption.
  - When mx_bus_req=0 at an edge and the other master's req=1, go directly to the other OWN state. There is no dead cycle; the grant moves on that same edge.
  - When mx_bus_req=0 and the other master's req=0, go to IDLE.
- last_owner updates to x whenever the FSM leaves OWNx.
- Slave mux is combinational:
  - OWN0: s_* = m0_*
  - OWN1: s_* = m1_*
  - IDLE: s_addr, s_wr, s_rd and s_wdata are all 0
- Strobes from the non-granted master never reach the slave side, even if that master asserts them.
- Hold counter:
  - Reset to 0 on entering any OWN state.
  - Increments by 1 each cycle in OWN state while the other master's req=1; saturates at all-ones.
  - Holds its value when the other master is not requesting.
  - In IDLE it stays 0.
- Watchdog:
  - Fires when the counter equals MAX_HOLD and the other master's req=1.
  - On the next edge: hold_viol<=1, and hold_viol_id<=current owner only if hold_viol was 0 (first-violation capture).
  - The grant itself is not affected.
- Clear: hold_viol_clr=1 clears both flags at the edge. If clear and a new violation occur in the same cycle, the set wins.
- Reset mid-operation: the grant drops on the edge where rst=1. Masters must tolerate losing the grant (the CPU re-requests).
- Simultaneous events: an owner releasing while both masters request goes to the other master, which is consistent with round-robin.

Test Plan:
- Reset, then m0_bus_req=1 only -> m0_bus_grant=1 one cycle later; m0_addr=0x3C with m0_wr=1, m0_wdata=0xA5 -> s_addr=0x3C, s_wr=1, s_wdata=0xA5 in that cycle; m1 strobes ignored.
- Both requests rise in the same cycle after reset -> M0 granted first. M0 drops req -> m1_bus_grant=1 on the very next edge with m0_bus_grant=0 (no gap). M1 drops, both then request together again -> M0 granted (last_owner=1).
- M1 owns the bus, M0 requests and holds: M1 keeps req for 10 cycles -> M0 stays ungranted for exactly those cycles, no preemption; M0 is granted on the edge where M1's req is sampled low.
- MAX_HOLD=4, M0 owns, M1 requests -> hold_viol=1 and hold_viol_id=0 after the 5th cycle of contention. Later an M1 violation -> hold_viol_id stays 0. hold_viol_clr pulse -> both flags return to 0.
- s_rdata=0x5A while M1 owns -> m_rdata=0x5A; in IDLE, s_addr=0x00 and s_wr=s_rd=0.
- rst=1 asserted while OWN1 -> next cycle both grants 0, s_* = 0, and the next tie grants M0.
